// File: rtl/pretu_col_transform.sv
// pretu_col_transform: column pass of the 2-D pre-transform; buffers one 4-row tile,
// then streams one transformed column per cycle downstream.
module pretu_col_transform #(
  parameter int A_bits = 12,
  parameter int ROWS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   mode,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [5:0][A_bits-1:0] in_row,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [5:0][A_bits-1:0] out_col,
  output logic [2:0]             out_col_idx,
  output logic                   out_last,
  output logic                   out_mode
);
  typedef enum logic {FILL, DRAIN} state_t;
  state_t state, state_nx;
  logic [1:0] row_cnt;
  logic tile_mode;
  logic [5:0][A_bits-1:0] tile [ROWS];
  logic row_xfer, col_xfer, last_row, last_col, fill_done, load_next;
  logic [2:0] src_c;
  logic [5:0][A_bits-1:0] nxt_col;

  // Operands are sign-extended by one bit and results truncated back, so overflow wraps.
  function automatic logic [5:0][A_bits-1:0] xform(input logic rf,
      input logic [A_bits-1:0] t0, t1, t2, t3);
    logic [A_bits:0] e0, e1, e2, e3;
    logic [5:0][A_bits:0] o;
    logic [5:0][A_bits-1:0] r;
    e0 = {t0[A_bits-1], t0};
    e1 = {t1[A_bits-1], t1};
    e2 = {t2[A_bits-1], t2};
    e3 = {t3[A_bits-1], t3};
    o[0] = rf ? e0 - e2 : e0 - e1;
    o[1] = rf ? e1 + e2 : e1;
    o[2] = e2 - e1;
    o[3] = rf ? e1 - e3 : e1 - e2;
    o[4] = rf ? '0 : e2;
    o[5] = rf ? '0 : e3 - e2;
    for (int i = 0; i < 6; i++) r[i] = o[i][A_bits-1:0];
    return r;
  endfunction

  assign row_xfer  = in_valid & in_ready;
  assign col_xfer  = out_valid & out_ready;
  assign last_row  = row_cnt == 2'(ROWS - 1);
  assign last_col  = out_col_idx == (out_mode ? 3'd3 : 3'd5);
  assign fill_done = row_xfer & last_row;
  assign load_next = col_xfer & ~last_col;
  // The final row is still on in_row when column 0 is formed, giving 1-cycle latency.
  assign src_c     = (state == FILL || last_col) ? 3'd0 : 3'(out_col_idx + 3'd1);
  assign nxt_col   = xform(tile_mode, tile[0][src_c], tile[1][src_c], tile[2][src_c],
                           state == FILL ? in_row[0] : tile[3][src_c]);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= FILL;
    else state <= state_nx;

  always_comb begin
    state_nx = state;
    if (state == FILL && fill_done) state_nx = DRAIN;
    if (state == DRAIN && col_xfer && last_col) state_nx = FILL;
  end

  always_comb in_ready = state == FILL;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      row_cnt   <= '0;
      tile_mode <= 1'b0;
    end else if (row_xfer) begin
      row_cnt <= last_row ? 2'd0 : row_cnt + 2'd1;
      if (row_cnt == 2'd0) tile_mode <= mode;
    end

  always_ff @(posedge clk)
    if (row_xfer) tile[row_cnt] <= in_row;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_col     <= '0;
      out_col_idx <= '0;
      out_last    <= 1'b0;
      out_mode    <= 1'b0;
    end else if (fill_done || load_next) begin
      out_valid   <= 1'b1;
      out_col     <= nxt_col;
      out_col_idx <= src_c;
      out_last    <= src_c == (tile_mode ? 3'd3 : 3'd5);
      out_mode    <= tile_mode;
    end else if (col_xfer) begin
      out_valid <= 1'b0;
    end
endmodule
